// File: rtl/de_stage_hz_pkg.sv
// Shared decode definitions for the decode stage: write-back source codes, the
// control bundle carried through ID/EX, and the control/immediate decoders.
package de_pkg;

  localparam logic [1:0] DATA_SRC_ALU = 2'b00;
  localparam logic [1:0] DATA_SRC_MEM = 2'b01;
  localparam logic [1:0] DATA_SRC_PC4 = 2'b10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_PASS_B = 4'b1001;
  localparam logic [4:0] BR_JUMP    = 5'b10000;

  typedef struct packed {
    logic       alu_a_src;
    logic       alu_b_src;
    logic       ru_wr;
    logic       dm_wr;
    logic [1:0] ru_data_wr_src;
    logic [3:0] alu_op;
    logic [4:0] br_op;
    logic [2:0] dm_ctrl;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = ctrl_t'('0);

  function automatic ctrl_t control_unit(input logic [31:0] inst);
    ctrl_t      c;
    logic [2:0] f3;
    c  = CTRL_BUBBLE;
    f3 = inst[14:12];
    case (inst[6:0])
      OP_REG:    begin c.ru_wr = 1'b1; c.alu_op = {inst[30], f3}; end
      OP_IMM:    begin
        c.ru_wr = 1'b1; c.alu_b_src = 1'b1;
        c.alu_op = {(f3 == 3'b101) & inst[30], f3};  // only shifts use funct7
      end
      OP_LOAD:   begin
        c.ru_wr = 1'b1; c.alu_b_src = 1'b1;
        c.ru_data_wr_src = DATA_SRC_MEM; c.dm_ctrl = f3;
      end
      OP_STORE:  begin c.dm_wr = 1'b1; c.alu_b_src = 1'b1; c.dm_ctrl = f3; end
      OP_BRANCH: begin c.alu_a_src = 1'b1; c.alu_b_src = 1'b1; c.br_op = {2'b01, f3}; end
      OP_JAL:    begin
        c.ru_wr = 1'b1; c.alu_a_src = 1'b1; c.alu_b_src = 1'b1;
        c.ru_data_wr_src = DATA_SRC_PC4; c.br_op = BR_JUMP;
      end
      OP_JALR:   begin
        c.ru_wr = 1'b1; c.alu_b_src = 1'b1;
        c.ru_data_wr_src = DATA_SRC_PC4; c.br_op = BR_JUMP;
      end
      OP_LUI:    begin c.ru_wr = 1'b1; c.alu_b_src = 1'b1; c.alu_op = ALU_PASS_B; end
      OP_AUIPC:  begin c.ru_wr = 1'b1; c.alu_a_src = 1'b1; c.alu_b_src = 1'b1; end
      default:   c = CTRL_BUBBLE;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] inst);
    logic [31:0] imm;
    case (inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR: imm = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:  imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm = {inst[31:12], 12'b0};
      OP_JAL:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:   imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/de_stage_hz_if.sv
// Decode-stage signal bundle: IF/DE inputs, write-back port, stall and ID/EX outputs.
interface de_stage_hz_if #(parameter int XLEN = 32);
  logic [31:0]     inst_de;
  logic [XLEN-1:0] pc_de;
  logic            valid_de;
  logic            flush;
  logic [XLEN-1:0] muxData;
  logic [4:0]      rd_wb;
  logic            RuWr_wb;
  logic            stall;
  logic            valid_ex;
  logic [XLEN-1:0] pc_ex, ru1_ex, ru2_ex, ImmExt_ex;
  logic [4:0]      rs1_ex, rs2_ex, rd_ex;
  logic            AluASrc_ex, AluBSrc_ex, RuWr_ex, DMWr_ex;
  logic [1:0]      RUDataWrSrc_ex;
  logic [3:0]      AluOp_ex;
  logic [4:0]      BrOp_ex;
  logic [2:0]      DMCtrl_ex;

  modport slave (
    input  inst_de, pc_de, valid_de, flush, muxData, rd_wb, RuWr_wb,
    output stall, valid_ex, pc_ex, ru1_ex, ru2_ex, ImmExt_ex, rs1_ex, rs2_ex, rd_ex,
           AluASrc_ex, AluBSrc_ex, RuWr_ex, DMWr_ex, RUDataWrSrc_ex, AluOp_ex,
           BrOp_ex, DMCtrl_ex
  );

  modport master (
    output inst_de, pc_de, valid_de, flush, muxData, rd_wb, RuWr_wb,
    input  stall, valid_ex, pc_ex, ru1_ex, ru2_ex, ImmExt_ex, rs1_ex, rs2_ex, rd_ex,
           AluASrc_ex, AluBSrc_ex, RuWr_ex, DMWr_ex, RUDataWrSrc_ex, AluOp_ex,
           BrOp_ex, DMCtrl_ex
  );
endinterface

// File: rtl/de_stage_hz_regfile.sv
// Architectural register file with optional same-cycle write-through to the read ports.
// Indices at or above NREG never write and always read zero.
module regfile_bypass #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  localparam int RW = $clog2(NREG);

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  logic            wr_ok, rs1_ok, rs2_ok;

  always_comb begin
    wr_ok  = wr_en && (rd != 5'd0) && (int'(rd) < NREG);
    rs1_ok = int'(rs1) < NREG;
    rs2_ok = int'(rs2) < NREG;
    rf_d   = rf_q;
    if (wr_ok) rf_d[rd[RW-1:0]] = wr_data;
    // entry 0 is never written, so x0 reads as zero without a special case
    rd1 = rs1_ok ? rf_q[rs1[RW-1:0]] : '0;
    rd2 = rs2_ok ? rf_q[rs2[RW-1:0]] : '0;
    if ((BYPASS != 0) && wr_ok && (rd == rs1)) rd1 = wr_data;
    if ((BYPASS != 0) && wr_ok && (rd == rs2)) rd2 = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rf_q <= '{default: '0};
    else     rf_q <= rf_d;
  end
endmodule

// File: rtl/de_stage_hz.sv
// Decode stage: register read with bypass, control/immediate decode, load-use stall,
// and the ID/EX register that takes a bubble on stall or flush.
module de_stage_hz #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  parameter int HAZARD = 1
) (
  input logic          clk,
  input logic          rst,
  de_stage_hz_if.slave bus
);
  import de_pkg::*;

  ctrl_t           ctrl_de, ctrl_d, ctrl_q;
  logic [XLEN-1:0] ru1_de, ru2_de, imm_de;
  logic            valid_d, valid_q;
  logic [XLEN-1:0] pc_d, pc_q, ru1_d, ru1_q, ru2_d, ru2_q, imm_d, imm_q;
  logic [4:0]      rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  logic            load_ex, hazard, stall;

  regfile_bypass #(.XLEN(XLEN), .NREG(NREG), .BYPASS(BYPASS)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .rs1     (bus.inst_de[19:15]),
    .rs2     (bus.inst_de[24:20]),
    .rd      (bus.rd_wb),
    .wr_en   (bus.RuWr_wb),
    .wr_data (bus.muxData),
    .rd1     (ru1_de),
    .rd2     (ru2_de)
  );

  always_comb begin
    ctrl_de = control_unit(bus.inst_de);
    imm_de  = XLEN'($signed(imm_gen(bus.inst_de)));
    load_ex = valid_q && ctrl_q.ru_wr && (ctrl_q.ru_data_wr_src == DATA_SRC_MEM)
              && (rd_q != 5'd0);
    // rs fields are compared whatever the format: an occasional spurious stall is harmless
    hazard  = load_ex && bus.valid_de
              && ((rd_q == bus.inst_de[19:15]) || (rd_q == bus.inst_de[24:20]));
    stall   = (HAZARD != 0) && hazard && !bus.flush;
  end

  always_comb begin
    valid_d = 1'b0;
    ctrl_d  = CTRL_BUBBLE;
    pc_d    = '0;
    ru1_d   = '0;
    ru2_d   = '0;
    imm_d   = '0;
    rs1_d   = '0;
    rs2_d   = '0;
    rd_d    = '0;
    if (!(bus.flush || stall)) begin
      valid_d = bus.valid_de;
      ctrl_d  = ctrl_de;
      pc_d    = bus.pc_de;
      ru1_d   = ru1_de;
      ru2_d   = ru2_de;
      imm_d   = imm_de;
      rs1_d   = bus.inst_de[19:15];
      rs2_d   = bus.inst_de[24:20];
      rd_d    = bus.inst_de[11:7];
      if (!bus.valid_de) begin
        ctrl_d.ru_wr = 1'b0;
        ctrl_d.dm_wr = 1'b0;
        ctrl_d.br_op = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_BUBBLE;
      pc_q    <= '0;
      ru1_q   <= '0;
      ru2_q   <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      ru1_q   <= ru1_d;
      ru2_q   <= ru2_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.stall          = stall;
  assign bus.valid_ex       = valid_q;
  assign bus.pc_ex          = pc_q;
  assign bus.ru1_ex         = ru1_q;
  assign bus.ru2_ex         = ru2_q;
  assign bus.ImmExt_ex      = imm_q;
  assign bus.rs1_ex         = rs1_q;
  assign bus.rs2_ex         = rs2_q;
  assign bus.rd_ex          = rd_q;
  assign bus.AluASrc_ex     = ctrl_q.alu_a_src;
  assign bus.AluBSrc_ex     = ctrl_q.alu_b_src;
  assign bus.RuWr_ex        = ctrl_q.ru_wr;
  assign bus.DMWr_ex        = ctrl_q.dm_wr;
  assign bus.RUDataWrSrc_ex = ctrl_q.ru_data_wr_src;
  assign bus.AluOp_ex       = ctrl_q.alu_op;
  assign bus.BrOp_ex        = ctrl_q.br_op;
  assign bus.DMCtrl_ex      = ctrl_q.dm_ctrl;
endmodule

// File: tb/tb_de_stage_hz.sv
// Directed bench for de_stage_hz: a bypassing RV32I instance and a non-bypassing RV32E
// instance share stimulus; expected ID/EX contents queue up as instructions are driven.
module tb_de_stage_hz;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  de_stage_hz_if #(.XLEN(32)) bus_a ();
  de_stage_hz_if #(.XLEN(32)) bus_b ();

  de_stage_hz #(.XLEN(32), .NREG(32), .BYPASS(1), .HAZARD(1)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  de_stage_hz #(.XLEN(32), .NREG(16), .BYPASS(0), .HAZARD(1)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  typedef struct packed {
    logic        valid;
    logic        ruwr;
    logic        chk_data;
    logic        chk_imm;
    logic [31:0] ru1;
    logic [31:0] ru2;
    logic [31:0] imm;
    logic [4:0]  rs1;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    checks = 0;
  int    passes = 0;
  int    fails  = 0;

  function automatic logic [31:0] enc_add(input logic [4:0] rd, rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_addi(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_lw(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [31:0] inst, input logic vld, input logic fl,
                       input logic wr, input logic [4:0] rd, input logic [31:0] data);
    bus_a.inst_de = inst;  bus_b.inst_de = inst;
    bus_a.valid_de = vld;  bus_b.valid_de = vld;
    bus_a.flush = fl;      bus_b.flush = fl;
    bus_a.RuWr_wb = wr;    bus_b.RuWr_wb = wr;
    bus_a.rd_wb = rd;      bus_b.rd_wb = rd;
    bus_a.muxData = data;  bus_b.muxData = data;
    bus_a.pc_de = 32'h0000_0040;  bus_b.pc_de = 32'h0000_0040;
    #1;
  endtask

  task automatic push_instr(input string tag, input logic [31:0] ru1, ru2,
                            input logic [4:0] rs1, input logic chk_imm, input logic [31:0] imm);
    exp_t e;
    e = '{valid: 1'b1, ruwr: 1'b1, chk_data: 1'b1, chk_imm: chk_imm,
          ru1: ru1, ru2: ru2, imm: imm, rs1: rs1};
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic push_bubble(input string tag);
    exp_t e;
    e = '{valid: 1'b0, ruwr: 1'b0, chk_data: 1'b0, chk_imm: 1'b0,
          ru1: '0, ru2: '0, imm: '0, rs1: '0};
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic tick();
    exp_t  e;
    string t;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check({t, "_valid"}, {31'b0, bus_a.valid_ex}, {31'b0, e.valid});
      check({t, "_ruwr"},  {31'b0, bus_a.RuWr_ex},  {31'b0, e.ruwr});
      if (e.chk_data) begin
        check({t, "_ru1"}, bus_a.ru1_ex, e.ru1);
        check({t, "_ru2"}, bus_a.ru2_ex, e.ru2);
        check({t, "_rs1"}, {27'b0, bus_a.rs1_ex}, {27'b0, e.rs1});
      end
      if (e.chk_imm) check({t, "_imm"}, bus_a.ImmExt_ex, e.imm);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_a_valid"}, {31'b0, bus_a.valid_ex}, 32'd0);
    check({tag, "_a_stall"}, {31'b0, bus_a.stall}, 32'd0);
    check({tag, "_a_allzero"}, {31'b0, |{bus_a.pc_ex, bus_a.ru1_ex, bus_a.ru2_ex,
          bus_a.ImmExt_ex, bus_a.rs1_ex, bus_a.rs2_ex, bus_a.rd_ex, bus_a.AluASrc_ex,
          bus_a.AluBSrc_ex, bus_a.RuWr_ex, bus_a.DMWr_ex, bus_a.RUDataWrSrc_ex,
          bus_a.AluOp_ex, bus_a.BrOp_ex, bus_a.DMCtrl_ex}}, 32'd0);
    check({tag, "_b_allzero"}, {31'b0, |{bus_b.valid_ex, bus_b.pc_ex, bus_b.ru1_ex,
          bus_b.ru2_ex, bus_b.ImmExt_ex, bus_b.rs1_ex, bus_b.rs2_ex, bus_b.rd_ex,
          bus_b.RuWr_ex, bus_b.DMWr_ex, bus_b.BrOp_ex, bus_b.stall}}, 32'd0);
  endtask

  initial begin
    logic [31:0] add_6_5_5, addi_1_0_7, lw_3_0_2, add_4_3_1, add_8_7_7, add_9_20_20, add_9_4_4;
    add_6_5_5   = enc_add(5'd6, 5'd5, 5'd5);
    addi_1_0_7  = enc_addi(5'd1, 5'd0, 12'd7);
    lw_3_0_2    = enc_lw(5'd3, 5'd2, 12'd0);
    add_4_3_1   = enc_add(5'd4, 5'd3, 5'd1);
    add_8_7_7   = enc_add(5'd8, 5'd7, 5'd7);
    add_9_20_20 = enc_add(5'd9, 5'd20, 5'd20);
    add_9_4_4   = enc_add(5'd9, 5'd4, 5'd4);

    rst = 1'b1;
    drive(32'h0000_0013, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset("rst0");
    rst = 1'b0;

    // write-back bypass: bypassing instance sees the new x5, the other sees the old value
    drive(add_6_5_5, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    push_instr("byp", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd5, 1'b0, 32'd0);
    tick();
    check("byp_off_ru1", bus_b.ru1_ex, 32'd0);
    drive(add_6_5_5, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    push_instr("byp_held", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd5, 1'b0, 32'd0);
    tick();
    check("byp_off_written", bus_b.ru2_ex, 32'hDEAD_BEEF);

    // x0 protection, both same-cycle and afterwards
    drive(addi_1_0_7, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0000_1234);
    push_instr("x0_same", 32'd0, 32'd0, 5'd0, 1'b1, 32'd7);
    tick();
    drive(addi_1_0_7, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    push_instr("x0_after", 32'd0, 32'd0, 5'd0, 1'b1, 32'd7);
    tick();

    // preload x1, x2 while DE holds a non-instruction whose controls must be dropped
    drive(add_4_3_1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h0000_0011);
    push_bubble("inv0");
    tick();
    drive(add_4_3_1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h0000_0100);
    push_bubble("inv1");
    tick();

    // load-use: one stall cycle, one bubble, then the add
    drive(lw_3_0_2, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    check("lu_pre_stall", {31'b0, bus_a.stall}, 32'd0);
    push_instr("lu_load", 32'h0000_0100, 32'd0, 5'd2, 1'b1, 32'd0);
    tick();
    drive(add_4_3_1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    check("lu_stall_a", {31'b0, bus_a.stall}, 32'd1);
    check("lu_stall_b", {31'b0, bus_b.stall}, 32'd1);
    push_bubble("lu_bubble");
    tick();
    drive(add_4_3_1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    check("lu_stall_drop", {31'b0, bus_a.stall}, 32'd0);
    push_instr("lu_add", 32'd0, 32'h0000_0011, 5'd3, 1'b0, 32'd0);
    tick();

    // flush beats stall
    drive(lw_3_0_2, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    push_instr("fl_load", 32'h0000_0100, 32'd0, 5'd2, 1'b0, 32'd0);
    tick();
    drive(add_4_3_1, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    check("fl_stall", {31'b0, bus_a.stall}, 32'd0);
    push_bubble("fl_bubble");
    tick();
    drive(addi_1_0_7, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    check("fl_next_stall", {31'b0, bus_a.stall}, 32'd0);
    push_instr("fl_next", 32'd0, 32'd0, 5'd0, 1'b1, 32'd7);
    tick();

    // reset while stalled and writing x7: outputs clear and the write is dropped
    drive(lw_3_0_2, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    push_instr("rs_load", 32'h0000_0100, 32'd0, 5'd2, 1'b0, 32'd0);
    tick();
    drive(add_4_3_1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0077);
    check("rs_stall", {31'b0, bus_a.stall}, 32'd1);
    rst = 1'b1;
    tick();
    check_reset("rs");
    rst = 1'b0;
    drive(add_8_7_7, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    push_instr("rs_x7", 32'd0, 32'd0, 5'd7, 1'b0, 32'd0);
    tick();
    check("rs_x7_b", bus_b.ru1_ex, 32'd0);

    // RV32E instance: x20 neither written nor readable, and does not alias x4
    drive(add_4_3_1, 1'b0, 1'b0, 1'b1, 5'd4, 32'h0000_0044);
    push_bubble("e_wr4");
    tick();
    drive(add_9_20_20, 1'b1, 1'b0, 1'b1, 5'd20, 32'h0000_AAAA);
    push_instr("e_byp20", 32'h0000_AAAA, 32'h0000_AAAA, 5'd20, 1'b0, 32'd0);
    tick();
    check("e_rd20_same_b", bus_b.ru1_ex, 32'd0);
    drive(add_9_20_20, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    push_instr("e_rd20", 32'h0000_AAAA, 32'h0000_AAAA, 5'd20, 1'b0, 32'd0);
    tick();
    check("e_rd20_b", bus_b.ru1_ex, 32'd0);
    check("e_rs1_b", {27'b0, bus_b.rs1_ex}, 32'd20);
    drive(add_9_4_4, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    push_instr("e_x4", 32'h0000_0044, 32'h0000_0044, 5'd4, 1'b0, 32'd0);
    tick();
    check("e_x4_b", bus_b.ru1_ex, 32'h0000_0044);

    check("sb_drain", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
